// File: rtl/dma_sched_pkg.sv
// Shared types and field layout for the S2MM write-command scheduler.
package dma_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    GAP
  } state_t;

  localparam int CMD_W      = 64;
  localparam int ADDR_MSB   = 63;
  localparam int ADDR_LSB   = 32;
  localparam int LEN_MSB    = 31;
  localparam int LEN_LSB    = 0;
  localparam int BEAT_BYTES = 16;
  localparam int BEAT_LSB_W = $clog2(BEAT_BYTES);

  // Command word as seen on req_cmd slices and W_DMA_CMD: address high, length low.
  typedef struct packed {
    logic [ADDR_MSB-ADDR_LSB:0] addr;
    logic [LEN_MSB-LEN_LSB:0]   len;
  } dma_cmd_t;

  // The DMA moves whole 16-byte beats, so empty or partial-beat lengths never reach it.
  function automatic logic cmd_filtered(input dma_cmd_t c);
    return (c.len == '0) || (c.len[BEAT_LSB_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         gnt_idx,
  output logic               any
);

  // Scan offsets 0..NUM_REQ-1 from the pointer; the first set request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any && req[j] && (j == (int'(ptr) + i) % NUM_REQ)) begin
          any     = 1'b1;
          gnt[j]  = 1'b1;
          gnt_idx = 3'(j);
        end
      end
    end
  end

endmodule

// File: rtl/dma_write_sched.sv
// Round-robin owner of the single S2MM write-command port: one command in
// flight, completion via rising edge of introut, hung transfers timed out.
module dma_write_sched
  import dma_sched_pkg::*;
#(
  parameter int NUM_REQ     = 2,      // 2..8
  parameter int TIMEOUT_CYC = 2**20,
  parameter int GAP_CYC     = 4       // >= 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][CMD_W-1:0] req_cmd,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          req_err,
  output logic [CMD_W-1:0]              W_DMA_CMD,
  output logic                          W_DMA_Valid,
  input  logic                          introut,
  output logic                          busy,
  output logic [2:0]                    grant_id,
  output logic                          err_timeout
);

  localparam int TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  state_t               state;
  logic [2:0]           rr_ptr;
  logic [2:0]           arb_idx;
  logic [2:0]           ptr_next;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [NUM_REQ-1:0]   gnt_q;
  logic                 arb_any;
  dma_cmd_t             sel_cmd;
  logic                 filt;
  logic                 introut_q;
  logic                 int_edge;
  logic [TO_W-1:0]      to_cnt;
  logic [GAP_W-1:0]     gap_cnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // One-hot mux of the granted requester's command word.
  always_comb begin
    sel_cmd = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (arb_gnt[j]) sel_cmd = dma_cmd_t'(req_cmd[j]);
    end
  end

  assign filt     = cmd_filtered(sel_cmd);
  assign ptr_next = (arb_idx == 3'(NUM_REQ - 1)) ? 3'd0 : arb_idx + 3'd1;
  assign int_edge = introut & ~introut_q;

  // Accept is same-cycle with the grant; gated by rst so reset shows no ready.
  assign req_ready = (rst && state == IDLE) ? arb_gnt : '0;

  // Previous introut level for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) introut_q <= 1'b0;
    else      introut_q <= introut;
  end

  // Scheduler FSM with registered strobes, status and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gnt_q       <= '0;
      grant_id    <= '0;
      W_DMA_CMD   <= '0;
      W_DMA_Valid <= 1'b0;
      req_done    <= '0;
      req_err     <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      W_DMA_Valid <= 1'b0;
      req_done    <= '0;
      req_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            gnt_q    <= arb_gnt;
            grant_id <= arb_idx;
            rr_ptr   <= ptr_next;
            busy     <= 1'b1;
            if (filt) begin
              // Bad length: report completion with error, DMA never sees it.
              state    <= DONE;
              req_done <= arb_gnt;
              req_err  <= 1'b1;
            end else begin
              state       <= ISSUE;
              W_DMA_Valid <= 1'b1;
              W_DMA_CMD   <= sel_cmd;
            end
          end
        end
        ISSUE: begin
          to_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          // A completion edge beats a simultaneous expiry.
          if (int_edge) begin
            state    <= DONE;
            req_done <= gnt_q;
          end else if (to_cnt == TO_LAST) begin
            state       <= DONE;
            req_done    <= gnt_q;
            req_err     <= 1'b1;
            err_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DONE: begin
          gap_cnt <= '0;
          state   <= GAP;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_write_sched.sv
// Scoreboard bench: a transaction-level round-robin model queues the expected
// grant order; a negedge monitor checks ready/strobe/done against it.
module tb_dma_write_sched;
  import dma_sched_pkg::*;

  localparam int N   = 3;
  localparam int TO  = 64;
  localparam int GAP = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [N-1:0]          req_valid;
  logic [N-1:0][63:0]    req_cmd;
  logic [N-1:0]          req_ready, req_done;
  logic                  req_err;
  logic [63:0]           W_DMA_CMD;
  logic                  W_DMA_Valid;
  logic                  introut;
  logic                  busy;
  logic [2:0]            grant_id;
  logic                  err_timeout;
  logic                  int_resp = 1'b0;
  logic                  int_stale = 1'b0;

  assign introut = int_resp | int_stale;

  dma_write_sched #(.NUM_REQ(N), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
    .W_DMA_CMD(W_DMA_CMD), .W_DMA_Valid(W_DMA_Valid), .introut(introut),
    .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event seen, none expected (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    int          idx;
    logic [63:0] cmd;
    bit          filt;
    int          lat;   // cycles strobe->introut rise; 0 = never rises
    bit          b2b;   // was pending when the previous command finished
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];
  int   model_ptr = 0;

  // staging area for the next batch, and what the requester drivers present
  logic [63:0] st_cmd [N][8];
  int          st_lat [N][8];
  int          st_cnt [N];
  logic [63:0] pd_cmd [N][8];
  int          pd_hd  [N];
  int          pd_tl  [N];
  bit          took   [N];

  task automatic add(input int r, input logic [31:0] addr, input logic [31:0] len, input int lat);
    st_cmd[r][st_cnt[r]] = {addr, len};
    st_lat[r][st_cnt[r]] = lat;
    st_cnt[r]++;
  endtask

  // Order the staged commands by round-robin over requester queue heads, then present them.
  task automatic run_batch();
    int p, tot, r, c;
    int hd [N];
    exp_t e;
    p = model_ptr;
    tot = 0;
    for (int i = 0; i < N; i++) begin hd[i] = 0; tot += st_cnt[i]; end
    for (int k = 0; k < tot; k++) begin
      r = -1;
      for (int off = 0; off < N; off++) begin
        c = (p + off) % N;
        if (r < 0 && hd[c] < st_cnt[c]) r = c;
      end
      e.idx  = r;
      e.cmd  = st_cmd[r][hd[r]];
      e.lat  = st_lat[r][hd[r]];
      e.filt = (e.cmd[31:0] == 32'd0) || ((e.cmd[31:0] % 16) != 0);
      e.b2b  = (k > 0);
      exp_q.push_back(e);
      if (!e.filt) lat_q.push_back(e.lat);
      hd[r]++;
      p = (r + 1) % N;
    end
    model_ptr = p;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < st_cnt[i]; j++) pd_cmd[i][j] = st_cmd[i][j];
      pd_hd[i]  = 0;
      pd_tl[i]  = st_cnt[i];
      st_cnt[i] = 0;
    end
  endtask

  // requesters: hold the head command until it is taken
  initial begin
    req_valid = '0;
    req_cmd   = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (took[i]) begin pd_hd[i]++; took[i] = 1'b0; end
        req_valid[i] = (pd_hd[i] < pd_tl[i]);
        if (req_valid[i]) req_cmd[i] = pd_cmd[i][pd_hd[i]];
        else              req_cmd[i] = 64'h0;
      end
    end
  end

  // DMA model: raise introut lat cycles after the strobe, hold 3 cycles
  initial begin
    int l;
    forever begin
      @(negedge clk);
      if (W_DMA_Valid && rst) begin
        l = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        if (l > 0) begin
          repeat (l) @(posedge clk);
          #1 int_resp = 1'b1;
          repeat (3) @(posedge clk);
          #1 int_resp = 1'b0;
        end
      end
    end
  end

  // monitor
  exp_t        cur;
  bit          have_cur = 1'b0;
  bit          strobed  = 1'b0;
  bit          sticky   = 1'b0;
  int          acc_cyc  = 0;
  int          strobe_cyc = 0;
  int          last_done = -100;
  logic [63:0] last_cmd = '0;
  int          exp_cyc;
  bit          exp_err;

  initial forever begin
    @(negedge clk);
    chk("busy", busy, have_cur ? (cyc > acc_cyc) : (cyc <= last_done + GAP));
    if (req_ready != '0) begin
      chk("ready_onehot", $countones(req_ready), 1);
      if (exp_q.size() == 0) fail("ready_unexpected");
      else begin
        cur      = exp_q.pop_front();
        have_cur = 1'b1;
        strobed  = 1'b0;
        acc_cyc  = cyc;
        chk("ready_idx", req_ready, 64'(1) << cur.idx);
        if (cur.b2b) chk("done_to_accept_gap", cyc - last_done, GAP + 1);
        for (int i = 0; i < N; i++) if (req_ready[i]) took[i] = 1'b1;
      end
    end
    if (W_DMA_Valid) begin
      if (!have_cur || cur.filt || strobed) fail("strobe_unexpected");
      else begin
        strobed    = 1'b1;
        strobe_cyc = cyc;
        last_cmd   = cur.cmd;
        chk("strobe_latency", cyc - acc_cyc, 1);
        chk("strobe_cmd", W_DMA_CMD, cur.cmd);
      end
    end
    if (req_done != '0) begin
      if (!have_cur) fail("done_unexpected");
      else begin
        if (cur.filt) begin
          exp_err = 1'b1; exp_cyc = acc_cyc + 1;
        end else if (!strobed) begin
          fail("done_without_strobe");
          exp_err = 1'b1; exp_cyc = cyc;
        end else if (cur.lat >= 1 && cur.lat <= TO) begin
          exp_err = 1'b0; exp_cyc = strobe_cyc + cur.lat + 1;
        end else begin
          exp_err = 1'b1; exp_cyc = strobe_cyc + TO + 1; sticky = 1'b1;
        end
        chk("done_idx", req_done, 64'(1) << cur.idx);
        chk("done_err", req_err, exp_err);
        chk("done_cycle", cyc, exp_cyc);
        chk("err_timeout", err_timeout, sticky);
        chk("grant_id", grant_id, cur.idx);
        chk("cmd_hold", W_DMA_CMD, last_cmd);
        last_done = cyc;
        have_cur  = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || have_cur || cyc <= last_done + GAP + 1) && n < 4000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 4000) fail("wait_idle_timeout");
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_req_done"}, req_done, 0);
    chk({tag, "_req_err"}, req_err, 0);
    chk({tag, "_dma_valid"}, W_DMA_Valid, 0);
    chk({tag, "_dma_cmd"}, W_DMA_CMD, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  initial begin
    int n, k, sel, len, lat;
    repeat (3) @(posedge clk);
    #2 chk_all_zero("reset");
    @(posedge clk); #3 rst = 1'b1;
    repeat (2) @(posedge clk); #2;

    // single command, completion 50 cycles after issue
    add(0, 32'h1000_0000, 32'h400, 50);
    run_batch(); wait_idle();

    // filtered lengths on r1
    add(1, 32'h1100_0000, 32'h0, 5);
    add(1, 32'h1100_0000, 32'h404, 5);
    run_batch(); wait_idle();

    // two requesters contending
    add(0, 32'h1200_0000, 32'h100, 8);
    add(0, 32'h1200_1000, 32'h200, 20);
    add(1, 32'h1300_0000, 32'h300, 3);
    add(1, 32'h1300_1000, 32'h40, 15);
    run_batch(); wait_idle();

    // completion edge exactly on the expiry cycle
    add(2, 32'h1400_0000, 32'h800, TO);
    run_batch(); wait_idle();

    // hung transfer, late edge, then a normal one
    add(0, 32'h1500_0000, 32'h10, 0);
    add(1, 32'h1600_0000, 32'h20, TO + 1);
    add(2, 32'h1700_0000, 32'h30, 7);
    run_batch(); wait_idle();

    // randomized batches
    for (int b = 0; b < 6; b++) begin
      for (int r = 0; r < N; r++) begin
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) begin
          sel = $urandom_range(0, 9);
          if (sel == 0)      len = 0;
          else if (sel == 1) len = ($urandom_range(0, 255) * 16) + $urandom_range(1, 15);
          else               len = $urandom_range(1, 256) * 16;
          sel = $urandom_range(0, 9);
          if (sel == 0)      lat = 0;
          else if (sel == 1) lat = TO;
          else               lat = $urandom_range(1, 40);
          add(r, $urandom(), 32'(len), lat);
        end
      end
      run_batch(); wait_idle();
    end

    // reset while waiting on the DMA
    add(2, 32'h2000_0000, 32'h100, 0);
    run_batch();
    n = 0;
    while (!strobed && n < 100) begin @(posedge clk); n++; end
    if (!strobed) fail("reset_phase_no_strobe");
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    int_stale = 1'b1;
    exp_q.delete(); lat_q.delete();
    have_cur = 1'b0; strobed = 1'b0; sticky = 1'b0;
    last_done = -100; model_ptr = 0;
    #1 chk_all_zero("async_reset");
    add(1, 32'h3000_0000, 32'h80, 12);
    run_batch();
    @(posedge clk); #2 chk("ready_in_reset", req_ready, 0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1 int_stale = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
